// File: rtl/matriz_serializador_resultado.sv
// Serializes the packed N x N add/subtract result matrix, one element per
// valid/ready transfer. Each 9-bit element is saturated to signed 8 bits
// before it leaves the block. A sticky flag records any clipping.
module matriz_serializador_resultado #(
   parameter int N = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [N*N*9-1:0]     matriz_resultado,
   output logic [7:0]           saida_dado,
   output logic [7:0]           saida_indice,
   output logic                 saida_valida,
   input  logic                 saida_pronta,
   output logic                 ultimo,
   output logic                 ocupado,
   output logic                 concluido,
   output logic                 saturou
);

   localparam int DATA_W = 9;
   localparam int TOTAL  = N * N;
   localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [7:0] ULTIMO_IDX = 8'(TOTAL - 1);

   typedef enum logic {
      OCIOSO,
      ENVIANDO
   } estado_t;

   estado_t estado, estado_prox;

   logic signed [DATA_W-1:0] elementos_p0 [TOTAL];
   logic [7:0]               indice;
   logic [IDX_W-1:0]         indice_arr;
   logic signed [DATA_W-1:0] elem;
   logic                     handshake;

   // Clamp a signed 9-bit result into the signed 8-bit storage range.
   function automatic logic [7:0] saturar(input logic signed [DATA_W-1:0] r);
      if (r > 9'sd127)
         return 8'h7F;
      else if (r < -9'sd128)
         return 8'h80;
      else
         return r[7:0];
   endfunction

   // True when saturar would change the value.
   function automatic logic clipou(input logic signed [DATA_W-1:0] r);
      return (r > 9'sd127) || (r < -9'sd128);
   endfunction

   assign indice_arr   = indice[IDX_W-1:0];
   assign elem         = elementos_p0[indice_arr];
   assign saida_valida = (estado == ENVIANDO);
   assign ocupado      = saida_valida;
   assign ultimo       = saida_valida && (indice == ULTIMO_IDX);
   assign saida_indice = indice;
   assign saida_dado   = saturar(elem);
   assign handshake    = saida_valida && saida_pronta;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         estado <= OCIOSO;
      else
         estado <= estado_prox;
   end

   // Next-state logic: capture on start when idle, leave after the final handshake.
   always_comb begin
      estado_prox = estado;
      case (estado)
         OCIOSO:   if (start) estado_prox = ENVIANDO;
         ENVIANDO: if (handshake && (indice == ULTIMO_IDX)) estado_prox = OCIOSO;
         default:  estado_prox = OCIOSO;
      endcase
   end

   // Capture register, element index, sticky clip flag and completion pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TOTAL; i++)
            elementos_p0[i] <= '0;
         indice    <= '0;
         saturou   <= 1'b0;
         concluido <= 1'b0;
      end else begin
         concluido <= 1'b0;
         if ((estado == OCIOSO) && start) begin
            for (int i = 0; i < TOTAL; i++)
               elementos_p0[i] <= matriz_resultado[i*DATA_W +: DATA_W];
            indice  <= '0;
            saturou <= 1'b0;
         end else if (handshake) begin
            if (clipou(elem))
               saturou <= 1'b1;
            if (indice == ULTIMO_IDX)
               concluido <= 1'b1;
            else
               indice <= indice + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_matriz_serializador_resultado.sv
// Testbench for matriz_serializador_resultado: directed scenarios plus random
// matrices, checked against a reference model built from plain integer arithmetic.
module tb_matriz_serializador_resultado;

   localparam int N     = 3;
   localparam int TOTAL = N * N;

   logic                 clk;
   logic                 reset;
   logic                 start;
   logic [TOTAL*9-1:0]   matriz_resultado;
   logic [7:0]           saida_dado;
   logic [7:0]           saida_indice;
   logic                 saida_valida;
   logic                 saida_pronta;
   logic                 ultimo;
   logic                 ocupado;
   logic                 concluido;
   logic                 saturou;

   int n_tests = 0;
   int n_fail  = 0;
   int cur [TOTAL];

   matriz_serializador_resultado #(.N(N)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .matriz_resultado (matriz_resultado),
      .saida_dado       (saida_dado),
      .saida_indice     (saida_indice),
      .saida_valida     (saida_valida),
      .saida_pronta     (saida_pronta),
      .ultimo           (ultimo),
      .ocupado          (ocupado),
      .concluido        (concluido),
      .saturou          (saturou)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference saturation on a plain integer, returned as the 8-bit pattern.
   function automatic int sat_ref(input int v);
      int s;
      s = v;
      if (v > 127)  s = 127;
      if (v < -128) s = -128;
      return s & 255;
   endfunction

   function automatic bit clip_ref(input int v);
      return (v > 127) || (v < -128);
   endfunction

   function automatic logic [TOTAL*9-1:0] pack_cur();
      logic [TOTAL*9-1:0] v;
      v = '0;
      for (int i = 0; i < TOTAL; i++)
         v[i*9 +: 9] = 9'(cur[i]);
      return v;
   endfunction

   function automatic int rand_elem();
      int r;
      r = int'($urandom_range(0, 511));
      return (r >= 256) ? r - 512 : r;
   endfunction

   // Streams cur[] through the DUT. Called at a negedge with the DUT idle
   // (or in its concluido cycle); returns at the negedge where concluido shows.
   task automatic stream(input int stall_idx, input int stall_len, input bit poke);
      int  k, cycles, stalls;
      bit  exp_sat, poked, pronta_now;
      matriz_resultado = pack_cur();
      start        = 1'b1;
      saida_pronta = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0; cycles = 0; stalls = 0; exp_sat = 1'b0; poked = 1'b0;
      while (k < TOTAL && cycles < TOTAL + 40) begin
         check("valid", int'(saida_valida), 1);
         check("ocupado", int'(ocupado), 1);
         check("dado", int'(saida_dado), sat_ref(cur[k]));
         check("indice", int'(saida_indice), k);
         check("ultimo", int'(ultimo), int'(k == TOTAL - 1));
         check("concluido_mid", int'(concluido), 0);
         check("saturou_mid", int'(saturou), int'(exp_sat));
         pronta_now = 1'b1;
         if (k == stall_idx && stalls < stall_len) begin
            pronta_now = 1'b0;
            stalls++;
         end
         saida_pronta = pronta_now;
         if (poke && !poked && k == 2) begin
            poked = 1'b1;
            start = 1'b1;
            matriz_resultado = ~pack_cur() ^ TOTAL*9'($urandom);
         end
         @(negedge clk);
         start = 1'b0;
         if (pronta_now) begin
            if (clip_ref(cur[k])) exp_sat = 1'b1;
            k++;
         end
         cycles++;
      end
      saida_pronta = 1'b1;
      check("cycles", cycles, TOTAL + ((stall_idx >= 0 && stall_idx < TOTAL) ? stall_len : 0));
      check("concluido", int'(concluido), 1);
      check("valid_end", int'(saida_valida), 0);
      check("saturou_end", int'(saturou), int'(exp_sat));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; saida_pronta = 1'b0; matriz_resultado = '0;
      for (int i = 0; i < TOTAL; i++) cur[i] = 0;
      @(negedge clk);
      check("rst_valid", int'(saida_valida), 0);
      check("rst_ocupado", int'(ocupado), 0);
      check("rst_ultimo", int'(ultimo), 0);
      check("rst_concluido", int'(concluido), 0);
      check("rst_saturou", int'(saturou), 0);
      check("rst_dado", int'(saida_dado), 0);
      check("rst_indice", int'(saida_indice), 0);
      reset = 1'b0;
      @(negedge clk);

      // Basic stream of 0..8
      for (int i = 0; i < TOTAL; i++) cur[i] = i;
      stream(-1, 0, 1'b0);
      @(negedge clk);
      check("concluido_pulse", int'(concluido), 0);

      // Saturation boundaries
      for (int i = 0; i < TOTAL; i++) cur[i] = i;
      cur[0] = 255; cur[1] = -129; cur[2] = -128; cur[3] = 127;
      stream(-1, 0, 1'b0);
      @(negedge clk);

      // Backpressure at index 4, three cycles
      for (int i = 0; i < TOTAL; i++) cur[i] = rand_elem();
      stream(4, 3, 1'b0);
      @(negedge clk);

      // Start while busy with input change at index 2
      for (int i = 0; i < TOTAL; i++) cur[i] = 10 * i - 40;
      stream(-1, 0, 1'b1);
      @(negedge clk);

      // Reset mid-transfer at index 5
      for (int i = 0; i < TOTAL; i++) cur[i] = i + 1;
      cur[0] = 200;
      matriz_resultado = pack_cur();
      start = 1'b1; saida_pronta = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge clk);
      check("abort_indice", int'(saida_indice), 5);
      check("abort_saturou_pre", int'(saturou), 1);
      #2 reset = 1'b1;
      #1;
      check("abort_valid", int'(saida_valida), 0);
      check("abort_ocupado", int'(ocupado), 0);
      check("abort_saturou", int'(saturou), 0);
      @(negedge clk);
      check("abort_concluido", int'(concluido), 0);
      reset = 1'b0;
      @(negedge clk);
      check("abort_concluido2", int'(concluido), 0);
      for (int i = 0; i < TOTAL; i++) cur[i] = 3 - i;
      stream(-1, 0, 1'b0);

      // Back-to-back: second start in the concluido cycle; first matrix clips
      for (int i = 0; i < TOTAL; i++) cur[i] = -200;
      stream(-1, 0, 1'b0);
      for (int i = 0; i < TOTAL; i++) cur[i] = i * 5;
      stream(-1, 0, 1'b0);
      @(negedge clk);

      // Random matrices, random stalls, random pokes, random back-to-back
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < TOTAL; i++) cur[i] = rand_elem();
         stream(int'($urandom_range(0, TOTAL + 2)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            check("idle_concluido", int'(concluido), 0);
            check("idle_valid", int'(saida_valida), 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/matriz_serializador_resultado.md
# matriz_serializador_resultado

Streams the packed N×N result matrix of the add/subtract datapath (9-bit two's-complement elements) out one element per transfer over a valid/ready handshake. Each element is saturated to signed 8 bits for write-back to 8-bit matrix storage. A sticky flag reports whether any element was clipped. The block sits between the arithmetic core and the memory-write path.

## Interface

- N, 3, matrix dimension; N*N ≤ 256
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  capture request; honoured only in OCIOSO
- matriz_resultado  in  N*N*9  packed result; element i at bits [i*9 +: 9], i = linha*N + coluna
- saida_dado  out  8  saturated element
- saida_indice  out  8  index i of saida_dado
- saida_valida  out  1  saida_dado/saida_indice/ultimo valid
- saida_pronta  in  1  consumer ready
- ultimo  out  1  high with the element i = N*N-1
- ocupado  out  1  high while in ENVIANDO
- concluido  out  1  one-cycle pulse after final transfer
- saturou  out  1  sticky: at least one transferred element of the current matrix was clipped

## Operation

- States:
  - **OCIOSO** (reset state)
    - start=1 → load matriz_resultado into an internal N*N*9 register; clear indice and saturou; go to ENVIANDO.
  - **ENVIANDO**
    - Present element indice.
    - On a handshake (saida_valida && saida_pronta) with indice < N*N-1: indice++ and stay in ENVIANDO.
    - On the handshake with indice = N*N-1: go to OCIOSO and pulse concluido.
- Saturation of each 9-bit element r (signed):
  - r > 127 → 8'h7F
  - r < -128 → 8'h80
  - otherwise r[7:0]
- saturou is set on a handshake whose element clipped. It stays set until the next accepted start or reset.
- start in ENVIANDO is ignored; the captured matrix is not altered.
- matriz_resultado is sampled only at the capture edge; later input changes do not affect the transfer.
- Outputs are combinational from registered state:
  - saida_valida = (state == ENVIANDO)
  - ocupado = saida_valida
  - ultimo = saida_valida && indice == N*N-1

## Timing

- Reset values: state OCIOSO; indice 0; saida_valida 0; ocupado 0; ultimo 0; concluido 0; saturou 0; saida_dado 0 (capture register cleared).
- Reset asserted mid-transfer returns to OCIOSO immediately (asynchronously). No concluido is generated, and the partial transfer is abandoned.
- Latency: start accepted at edge k → saida_valida=1 with element 0 in the cycle following edge k.
- Throughput: with saida_pronta held at 1, one element per cycle. N*N consecutive cycles of valid; last handshake at edge k+N*N.
- Backpressure: while saida_valida && !saida_pronta, saida_dado, saida_indice and ultimo hold stable.
- saida_valida never drops before the element is accepted.
- concluido is high for exactly the cycle after the final handshake edge; state is OCIOSO in that cycle.
- start asserted in that same cycle is accepted. Back-to-back matrices then have one idle cycle between them.
- saturou is valid together with concluido and holds afterward.

## Test plan

1. Basic stream, N=3, saida_pronta=1
   - Stimulus: elements 0..8 = 9'h000..9'h008, pulse start.
   - Required: saida_dado 0x00..0x08 on nine consecutive cycles, saida_indice 0..8, ultimo only with index 8.
   - Required: concluido one cycle later; saturou=0.
2. Saturation
   - Stimulus: element0=9'h0FF (255), element1=9'h17F (-129), element2=9'h180 (-128), element3=9'h07F (127).
   - Required: outputs 0x7F, 0x80, 0x80, 0x7F.
   - Required: saturou rises after the index-0 handshake and is 1 at concluido.
3. Backpressure
   - Stimulus: hold saida_pronta=0 for 3 cycles at index 4.
   - Required: saida_dado/saida_indice stay at element 4 and saida_valida stays 1.
   - Required: total transfer takes 12 cycles; no element is skipped or duplicated.
4. Start while busy and input change
   - Stimulus: pulse start and change matriz_resultado at index 2.
   - Required: the stream continues with the originally captured values; no restart.
5. Reset mid-transfer
   - Stimulus: assert reset at index 5, between clock edges.
   - Required: saida_valida, ocupado and saturou drop without waiting for an edge; no concluido pulse.
   - Required: a subsequent start streams a new matrix from index 0.
6. Back-to-back
   - Stimulus: assert start during the concluido cycle.
   - Required: the second matrix starts with index 0 on the following cycle; saturou is cleared for the second matrix.
